// File: rtl/block_plot_ctrl_pkg.sv
// Shared constants and types for the block plotter: geometry defaults, coordinate widths, FSM states.
package block_plot_ctrl_pkg;

  localparam int unsigned BLK_SIZE = 4;
  localparam int unsigned MAX_LEN  = 8;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned C_W      = 3;
  localparam int unsigned LEN_W    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPlot,
    StDone
  } state_e;

endpackage

// File: rtl/block_plot_ctrl_if.sv
// Requester handshake plus VGA pixel/status bundle; slave side is the plot controller.
interface block_plot_ctrl_if;
  import block_plot_ctrl_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [X_W-1:0]   req_x0;
  logic [X_W-1:0]   req_x1;
  logic [Y_W-1:0]   req_y0;
  logic [Y_W-1:0]   req_y1;
  logic [LEN_W-1:0] req_len0;
  logic [LEN_W-1:0] req_len1;
  logic [C_W-1:0]   req_colour0;
  logic [C_W-1:0]   req_colour1;
  logic [X_W-1:0]   x_out;
  logic [Y_W-1:0]   y_out;
  logic [C_W-1:0]   colour_out;
  logic             plot;
  logic             busy;
  logic             done;
  logic             done_id;

  modport slave (
    input  req_valid, req_x0, req_x1, req_y0, req_y1, req_len0, req_len1,
           req_colour0, req_colour1,
    output req_ready, x_out, y_out, colour_out, plot, busy, done, done_id
  );

  modport master (
    output req_valid, req_x0, req_x1, req_y0, req_y1, req_len0, req_len1,
           req_colour0, req_colour1,
    input  req_ready, x_out, y_out, colour_out, plot, busy, done, done_id
  );

endinterface

// File: rtl/block_pixel_counter.sv
// Walks cx (fastest), then cy, then block index; flags the final pixel of a row of len blocks.
module block_pixel_counter
  import block_plot_ctrl_pkg::*;
#(
  parameter int unsigned BLK_SIZE = block_plot_ctrl_pkg::BLK_SIZE,
  localparam int unsigned CW = $clog2(BLK_SIZE)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [LEN_W-1:0] len,
  output logic [CW-1:0]    cx,
  output logic [CW-1:0]    cy,
  output logic             last_pixel
);

  localparam logic [CW-1:0] CMAX = CW'(BLK_SIZE - 1);

  logic [CW-1:0]    cx_q;
  logic [CW-1:0]    cy_q;
  logic [LEN_W-1:0] blk_q;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cx_q  <= '0;
      cy_q  <= '0;
      blk_q <= '0;
    end else if (enable) begin
      if (cx_q == CMAX) begin
        cx_q <= '0;
        if (cy_q == CMAX) begin
          cy_q  <= '0;
          blk_q <= blk_q + LEN_W'(1);
        end else begin
          cy_q <= cy_q + CW'(1);
        end
      end else begin
        cx_q <= cx_q + CW'(1);
      end
    end
  end

  assign cx         = cx_q;
  assign cy         = cy_q;
  assign last_pixel = (cx_q == CMAX) && (cy_q == CMAX) && (blk_q == len - LEN_W'(1));

endmodule

// File: rtl/block_plot_ctrl.sv
// Two-requester round-robin block-row plotter: emits one VGA pixel write per cycle, cx-first.
module block_plot_ctrl
  import block_plot_ctrl_pkg::*;
#(
  parameter int unsigned BLK_SIZE = block_plot_ctrl_pkg::BLK_SIZE,
  parameter int unsigned MAX_LEN  = block_plot_ctrl_pkg::MAX_LEN
) (
  input logic               clk,
  input logic               resetn,
  block_plot_ctrl_if.slave  bus
);

  localparam int unsigned   CW   = $clog2(BLK_SIZE);
  localparam logic [CW-1:0] CMAX = CW'(BLK_SIZE - 1);

  state_e           state_q;
  logic             prio_q;
  logic             id_q;
  logic [LEN_W-1:0] len_q;
  logic [Y_W-1:0]   y0_q;
  logic [X_W-1:0]   x_out_q;
  logic [Y_W-1:0]   y_out_q;
  logic [C_W-1:0]   colour_out_q;
  logic             plot_q;
  logic             busy_q;
  logic             done_q;
  logic             done_id_q;

  logic             gnt_any;
  logic             gnt_id;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [LEN_W-1:0] sel_len;
  logic [LEN_W-1:0] len_eff;
  logic [C_W-1:0]   sel_colour;
  logic [CW-1:0]    cx;
  logic [CW-1:0]    cy;
  logic             last_pixel;

  // The requester not served last is checked first.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = prio_q;
    if (bus.req_valid[prio_q]) begin
      gnt_any = 1'b1;
    end else if (bus.req_valid[~prio_q]) begin
      gnt_any = 1'b1;
      gnt_id  = ~prio_q;
    end
  end

  assign bus.req_ready = (state_q == StIdle && gnt_any) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  assign sel_x      = gnt_id ? bus.req_x1 : bus.req_x0;
  assign sel_y      = gnt_id ? bus.req_y1 : bus.req_y0;
  assign sel_len    = gnt_id ? bus.req_len1 : bus.req_len0;
  assign sel_colour = gnt_id ? bus.req_colour1 : bus.req_colour0;
  assign len_eff    = (sel_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : sel_len;

  block_pixel_counter #(
    .BLK_SIZE (BLK_SIZE)
  ) u_counter (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (state_q == StIdle),
    .enable     (state_q == StPlot && !last_pixel),
    .len        (len_q),
    .cx         (cx),
    .cy         (cy),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      len_q        <= '0;
      y0_q         <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_any) begin
            prio_q <= ~gnt_id;
            id_q   <= gnt_id;
            len_q  <= len_eff;
            y0_q   <= sel_y;
            busy_q <= 1'b1;
            if (len_eff == '0) begin
              state_q   <= StDone;
              done_q    <= 1'b1;
              done_id_q <= gnt_id;
            end else begin
              // First pixel is presented on the handshake edge itself.
              state_q      <= StPlot;
              plot_q       <= 1'b1;
              x_out_q      <= sel_x;
              y_out_q      <= sel_y;
              colour_out_q <= sel_colour;
            end
          end
        end
        StPlot: begin
          if (last_pixel) begin
            state_q   <= StDone;
            plot_q    <= 1'b0;
            done_q    <= 1'b1;
            done_id_q <= id_q;
          end else if (cx == CMAX) begin
            if (cy == CMAX) begin
              // Next block starts one pixel right of this block's last column.
              x_out_q <= x_out_q + X_W'(1);
              y_out_q <= y0_q;
            end else begin
              x_out_q <= x_out_q - X_W'(BLK_SIZE - 1);
              y_out_q <= y_out_q + Y_W'(1);
            end
          end else begin
            x_out_q <= x_out_q + X_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.colour_out = colour_out_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.done_id    = done_id_q;

endmodule

// File: doc/block_plot_ctrl.md
BLOCK_PLOT_CTRL -- requirements
Module: block_plot_ctrl

Interface
REQ-001 The block SHALL have parameter BLK_SIZE, default 4, giving the square block edge in pixels (power of two).
REQ-002 The block SHALL have parameter MAX_LEN, default 8, giving the maximum number of blocks per row request.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port resetn, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have ports req_valid, input, 2, and req_ready, output, 2, carrying the per-requester valid/ready handshake (bit 0 = game draw, bit 1 = erase).
REQ-006 The block SHALL have ports req_x0/req_x1, input, 8, and req_y0/req_y1, input, 7, carrying the per-requester top-left pixel of the row.
REQ-007 The block SHALL have ports req_len0/req_len1, input, 4, carrying the per-requester block count.
REQ-008 The block SHALL have ports req_colour0/req_colour1, input, 3, carrying the per-requester fill colour.
REQ-009 The block SHALL have ports x_out, output, 8, and y_out, output, 7, carrying the current pixel coordinates to the VGA adapter.
REQ-010 The block SHALL have port colour_out, output, 3, carrying the current pixel colour.
REQ-011 The block SHALL have port plot, output, 1, the VGA write enable, high for exactly one cycle per pixel.
REQ-012 The block SHALL have ports busy, output, 1, high outside IDLE, and done, output, 1, a one-cycle pulse on completion of a request.
REQ-013 The block SHALL have port done_id, output, 1, identifying the requester served; it is valid while done is high.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, PLOT and DONE.
REQ-015 In IDLE, req_ready SHALL be asserted combinationally for the one requester selected by round-robin among asserted req_valid bits; req_ready SHALL be 0 in all other states.
REQ-016 Round-robin SHALL give priority to the requester not granted last; after reset, requester 0 has priority.
REQ-017 On a handshake (valid&ready), the block SHALL latch x, y, colour, requester id and the effective length in the same edge, then move to PLOT.
REQ-018 Effective length SHALL be len clamped to MAX_LEN; a latched length of 0 SHALL go from the handshake directly to DONE without plotting.
REQ-019 In PLOT, the block SHALL assert plot every cycle with x_out = x + BLK_SIZE*blk + cx (mod 256), y_out = y + cy (mod 128), and colour_out = latched colour.
REQ-020 Counter order SHALL be cx fastest (0..BLK_SIZE-1), then cy, then blk (0..len-1).
REQ-021 PLOT SHALL last exactly BLK_SIZE*BLK_SIZE*len cycles, after which the block moves to DONE.
REQ-022 DONE SHALL last one cycle with done=1, plot=0, done_id = latched id, and then return to IDLE.
REQ-023 Minimum handshake-to-handshake spacing SHALL therefore be 16*len+2 cycles.
REQ-024 Request inputs SHALL be ignored outside the IDLE handshake; a request changing mid-plot SHALL not affect the pixels being drawn.
REQ-025 When plot=0, x_out, y_out and colour_out SHALL hold their last values.

Reset
REQ-026 While resetn=0 at a clock edge, the block SHALL enter IDLE, clear all counters, and drive plot=0, done=0, busy=0, done_id=0, x_out=0, y_out=0, colour_out=0 and round-robin pointer = requester 0.
REQ-027 A reset asserted mid-PLOT SHALL abort the row with no done pulse; the first cycle after release is IDLE.

Structure
REQ-028 A shared package SHALL hold BLK_SIZE, MAX_LEN, the FSM state enumeration and coordinate width constants (X_W=8, Y_W=7, C_W=3).
REQ-029 The block SHALL contain one sub-module, block_pixel_counter, holding cx/cy/blk, with inputs clear, enable and len, and output last_pixel.

Verification
REQ-030 Single draw: req0 x=10,y=20,len=1,colour=3'b100 -> 16 plot cycles covering x 10..13 and y 20..23 in cx-first order, then done=1 with done_id=0.
REQ-031 Row: req1 x=0,y=0,len=3 -> 48 plot cycles, last pixel (11,3), then done_id=1.
REQ-032 Contention: both valid continuously with len=1 -> grants alternate 0,1,0,1, with handshakes 18 cycles apart.
REQ-033 Wrap/clamp: x=254,y=126,len=12 -> length treated as 8 (128 plots), x wraps to 0..29, y covers 126,127,0,1.
REQ-034 len=0: handshake followed by done on the next cycle, with no plot pulses.
REQ-035 Reset at the 7th PLOT cycle -> plot=0, busy=0 the next cycle, no done pulse, and priority returns to requester 0.
